// File: rtl/pipeline_run_ctrl.sv
// pipeline_run_ctrl: sequences one pipeline run (reset window, free-run or
// single-step execution, termination on halt/stall/timeout) and counts
// enabled cycles and retired instructions.
//   clk, rst        clock, synchronous active-low reset
//   start, abort    run control (abort wins over start)
//   step_mode, step single-step control (step is edge-detected)
//   halt_in, retire pipeline status, honoured only while core_en=1
//   core_rst_n, core_en  pipeline reset / advance enable
//   cycle_cnt, retire_cnt, busy, done, reason  run status
module pipeline_run_ctrl #(
  parameter int RST_CYCLES = 2,
  parameter int MAX_CYCLES = 2000,
  parameter int IDLE_LIMIT = 64,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             step_mode,
  input  logic             step,
  input  logic             halt_in,
  input  logic             retire,
  output logic             core_rst_n,
  output logic             core_en,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retire_cnt,
  output logic             busy,
  output logic             done,
  output logic [1:0]       reason
);

  typedef enum logic [1:0] {IDLE, RESET, RUN, DONE} state_t;

  localparam logic [1:0]  R_NONE    = 2'b00;
  localparam logic [1:0]  R_HALT    = 2'b01;
  localparam logic [1:0]  R_TIMEOUT = 2'b10;
  localparam logic [1:0]  R_STALL   = 2'b11;
  localparam logic [31:0] RST_LAST  = 32'(RST_CYCLES - 1);

  state_t           state_q, state_d;
  logic [31:0]      rcnt_q, rcnt_d;
  logic [CNT_W-1:0] idle_q, idle_d;
  logic [CNT_W-1:0] cyc_d, ret_d, cyc_inc, ret_inc, idle_inc;
  logic [1:0]       reason_d;
  logic             en_d;
  logic             step_q;
  logic             step_rise;

  assign step_rise = step & ~step_q;

  assign core_rst_n = (state_q == RUN) || (state_q == DONE);
  assign busy       = (state_q == RESET) || (state_q == RUN);
  assign done       = (state_q == DONE);

  always_comb begin
    state_d  = state_q;
    rcnt_d   = rcnt_q;
    cyc_d    = cycle_cnt;
    ret_d    = retire_cnt;
    idle_d   = idle_q;
    reason_d = reason;
    cyc_inc  = (cycle_cnt == '1) ? cycle_cnt : cycle_cnt + CNT_W'(1);
    ret_inc  = (retire_cnt == '1) ? retire_cnt : retire_cnt + CNT_W'(1);
    idle_inc = (idle_q == '1) ? idle_q : idle_q + CNT_W'(1);

    if (abort) begin
      state_d  = IDLE;
      rcnt_d   = '0;
      cyc_d    = '0;
      ret_d    = '0;
      idle_d   = '0;
      reason_d = R_NONE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d  = RESET;
            rcnt_d   = '0;
            cyc_d    = '0;
            ret_d    = '0;
            idle_d   = '0;
            reason_d = R_NONE;
          end
        end
        RESET: begin
          if (rcnt_q == RST_LAST) state_d = RUN;
          else                    rcnt_d  = rcnt_q + 32'd1;
        end
        RUN: begin
          if (core_en) begin
            cyc_d  = cyc_inc;
            ret_d  = retire ? ret_inc : retire_cnt;
            idle_d = retire ? '0 : idle_inc;
            // Terminations are judged on the updated counts; halt > stall > timeout.
            if (halt_in) begin
              state_d  = DONE;
              reason_d = R_HALT;
            end else if ((IDLE_LIMIT != 0) && (idle_d == CNT_W'(IDLE_LIMIT))) begin
              state_d  = DONE;
              reason_d = R_STALL;
            end else if (cyc_d == CNT_W'(MAX_CYCLES)) begin
              state_d  = DONE;
              reason_d = R_TIMEOUT;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // core_en is registered alongside the state so the first RUN cycle is enabled.
    en_d = (state_d == RUN) && (!step_mode || step_rise);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      rcnt_q     <= '0;
      idle_q     <= '0;
      cycle_cnt  <= '0;
      retire_cnt <= '0;
      reason     <= R_NONE;
      core_en    <= 1'b0;
      step_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rcnt_q     <= rcnt_d;
      idle_q     <= idle_d;
      cycle_cnt  <= cyc_d;
      retire_cnt <= ret_d;
      reason     <= reason_d;
      core_en    <= en_d;
      step_q     <= step;
    end
  end

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
module tb_pipeline_run_ctrl;

  localparam int RST_CYCLES = 2;
  localparam int MAX_CYCLES = 20;
  localparam int IDLE_LIMIT = 4;
  localparam int CNT_W      = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, abort, step_mode, step, halt_in, retire;
  logic core_rst_n, core_en, busy, done;
  logic [CNT_W-1:0] cycle_cnt, retire_cnt;
  logic [1:0] reason;

  int vectors = 0;
  int miscompares = 0;

  pipeline_run_ctrl #(
    .RST_CYCLES(RST_CYCLES),
    .MAX_CYCLES(MAX_CYCLES),
    .IDLE_LIMIT(IDLE_LIMIT),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .step_mode(step_mode), .step(step), .halt_in(halt_in), .retire(retire),
    .core_rst_n(core_rst_n), .core_en(core_en),
    .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt),
    .busy(busy), .done(done), .reason(reason)
  );

  typedef struct packed {
    logic start, abort, halt_in, retire;
    logic e_rstn, e_en, e_busy, e_done;
    logic [1:0] e_reason;
    logic [7:0] e_cyc, e_ret;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic s, a, h, r, rn, en, b, d,
                             input logic [1:0] rs, input logic [7:0] c, rt);
    v = {s, a, h, r, rn, en, b, d, rs, c, rt};
  endfunction

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic rn, en, b, d,
                         input logic [1:0] rs, input logic [7:0] c, rt);
    vectors++;
    if ({core_rst_n, core_en, busy, done, reason, cycle_cnt, retire_cnt} !==
        {rn, en, b, d, rs, c, rt}) begin
      miscompares++;
      $display("FAIL %s: got rstn=%b en=%b busy=%b done=%b reason=%b cyc=%0d ret=%0d; expected rstn=%b en=%b busy=%b done=%b reason=%b cyc=%0d ret=%0d",
               name, core_rst_n, core_en, busy, done, reason, cycle_cnt, retire_cnt,
               rn, en, b, d, rs, c, rt);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; start = 1'b0; abort = 1'b0; step_mode = 1'b0;
    step = 1'b0; halt_in = 1'b0; retire = 1'b0;
    next();
    rst = 1'b1;
  endtask

  task automatic run_until_done(input int limit, output int ens, output bit ok);
    ens = 0;
    ok  = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (done) begin
        ok = 1'b1;
        return;
      end
      ens += int'(core_en);
      next();
    end
  endtask

  // Reference model: run phase as plain integers, reset window as a countdown.
  int m_phase;  // 0 idle, 1 reset window, 2 running, 3 finished
  int m_rleft, m_cyc, m_ret, m_idle, m_reason;
  bit m_en, m_prev;

  task automatic model_step();
    bit rise;
    rise = step && !m_prev;
    if (!rst || abort) begin
      m_phase = 0; m_cyc = 0; m_ret = 0; m_idle = 0; m_reason = 0;
      m_en = 1'b0;
      m_prev = rst ? step : 1'b0;
      return;
    end
    if ((m_phase == 0 || m_phase == 3) && start) begin
      m_phase = 1; m_rleft = RST_CYCLES;
      m_cyc = 0; m_ret = 0; m_idle = 0; m_reason = 0;
    end else if (m_phase == 1) begin
      m_rleft--;
      if (m_rleft == 0) m_phase = 2;
    end else if (m_phase == 2 && m_en) begin
      if (m_cyc < 255) m_cyc++;
      if (retire && m_ret < 255) m_ret++;
      m_idle = retire ? 0 : m_idle + 1;
      if (halt_in)                                  begin m_phase = 3; m_reason = 1; end
      else if (IDLE_LIMIT > 0 && m_idle == IDLE_LIMIT) begin m_phase = 3; m_reason = 3; end
      else if (m_cyc == MAX_CYCLES)                 begin m_phase = 3; m_reason = 2; end
    end
    m_en   = (m_phase == 2) && (!step_mode || rise);
    m_prev = step;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  ens;
    bit  ok;
    bit  pat[14];

    do_reset();
    rst = 1'b0;
    next();
    chk_out("reset_state", 0, 0, 0, 0, 2'b00, 8'd0, 8'd0);
    rst = 1'b1;

    //            st ab h  r   rn en b  d  rs     cyc  ret
    tbl.push_back(v(1, 0, 0, 1,  0, 0, 0, 0, 2'b00, 8'd0, 8'd0));
    tbl.push_back(v(0, 0, 0, 1,  0, 0, 1, 0, 2'b00, 8'd0, 8'd0));
    tbl.push_back(v(0, 0, 0, 1,  0, 0, 1, 0, 2'b00, 8'd0, 8'd0));
    tbl.push_back(v(0, 0, 0, 1,  1, 1, 1, 0, 2'b00, 8'd0, 8'd0));
    tbl.push_back(v(0, 0, 0, 1,  1, 1, 1, 0, 2'b00, 8'd1, 8'd1));
    tbl.push_back(v(0, 0, 0, 1,  1, 1, 1, 0, 2'b00, 8'd2, 8'd2));
    tbl.push_back(v(0, 0, 0, 1,  1, 1, 1, 0, 2'b00, 8'd3, 8'd3));
    tbl.push_back(v(0, 0, 0, 1,  1, 1, 1, 0, 2'b00, 8'd4, 8'd4));
    tbl.push_back(v(0, 0, 1, 1,  1, 1, 1, 0, 2'b00, 8'd5, 8'd5));
    tbl.push_back(v(0, 0, 1, 1,  1, 0, 0, 1, 2'b01, 8'd6, 8'd6));
    tbl.push_back(v(0, 0, 0, 0,  1, 0, 0, 1, 2'b01, 8'd6, 8'd6));
    tbl.push_back(v(1, 0, 0, 1,  1, 0, 0, 1, 2'b01, 8'd6, 8'd6));
    tbl.push_back(v(0, 0, 0, 1,  0, 0, 1, 0, 2'b00, 8'd0, 8'd0));
    tbl.push_back(v(0, 0, 0, 1,  0, 0, 1, 0, 2'b00, 8'd0, 8'd0));
    tbl.push_back(v(1, 1, 0, 1,  1, 1, 1, 0, 2'b00, 8'd0, 8'd0));
    tbl.push_back(v(0, 0, 0, 0,  0, 0, 0, 0, 2'b00, 8'd0, 8'd0));

    foreach (tbl[i]) begin
      start = tbl[i].start; abort = tbl[i].abort;
      halt_in = tbl[i].halt_in; retire = tbl[i].retire;
      chk_out($sformatf("table_row%0d", i), tbl[i].e_rstn, tbl[i].e_en, tbl[i].e_busy,
              tbl[i].e_done, tbl[i].e_reason, tbl[i].e_cyc, tbl[i].e_ret);
      next();
    end

    // Timeout after MAX_CYCLES enabled cycles.
    do_reset();
    start = 1'b1; retire = 1'b1;
    next();
    start = 1'b0;
    run_until_done(60, ens, ok);
    chk("timeout_reached", 32'(ok), 32'd1);
    chk("timeout_en_count", 32'(ens), 32'd20);
    chk_out("timeout_final", 1, 0, 0, 1, 2'b10, 8'd20, 8'd20);
    for (int i = 0; i < 3; i++) begin
      next();
      chk($sformatf("timeout_en_low%0d", i), 32'(core_en), 32'd0);
    end

    // Stall with no retire.
    do_reset();
    start = 1'b1;
    next();
    start = 1'b0;
    run_until_done(30, ens, ok);
    chk("stall_reached", 32'(ok), 32'd1);
    chk("stall_en_count", 32'(ens), 32'd4);
    chk_out("stall_final", 1, 0, 0, 1, 2'b11, 8'd4, 8'd0);

    // Halt coinciding with the stall cycle wins.
    do_reset();
    start = 1'b1;
    next();
    start = 1'b0;
    ens = 0;
    for (int i = 0; i < 30 && !done; i++) begin
      halt_in = core_en && (ens == 3);
      ens += int'(core_en);
      next();
    end
    halt_in = 1'b0;
    chk_out("halt_over_stall", 1, 0, 0, 1, 2'b01, 8'd4, 8'd0);

    // Single-step: held-high step gives one enable, then three pulses.
    do_reset();
    step_mode = 1'b1; retire = 1'b1; start = 1'b1;
    next();
    start = 1'b0;
    next();
    next();
    pat = '{1, 1, 1, 1, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0};
    ens = 0;
    for (int i = 0; i < 14; i++) begin
      step = pat[i];
      ens += int'(core_en);
      next();
    end
    chk("step_en_count", 32'(ens), 32'd4);
    chk_out("step_final", 1, 0, 1, 0, 2'b00, 8'd4, 8'd4);

    // start ignored in RUN, abort beats start, fresh reset window, rst mid-run.
    do_reset();
    retire = 1'b1; start = 1'b1;
    next();
    start = 1'b0;
    next(); next(); next(); next();
    start = 1'b1;
    next();
    start = 1'b0;
    chk("start_ignored_in_run", 32'({busy, core_rst_n, core_en, done}), 32'b1110);
    chk("start_ignored_cnt", 32'(cycle_cnt), 32'd3);
    abort = 1'b1; start = 1'b1;
    next();
    abort = 1'b0; start = 1'b0;
    chk_out("abort_beats_start", 0, 0, 0, 0, 2'b00, 8'd0, 8'd0);
    for (int r = 0; r < 2; r++) begin
      start = 1'b1;
      next();
      start = 1'b0;
      chk_out($sformatf("rstwin%0d_c1", r), 0, 0, 1, 0, 2'b00, 8'd0, 8'd0);
      next();
      chk_out($sformatf("rstwin%0d_c2", r), 0, 0, 1, 0, 2'b00, 8'd0, 8'd0);
      next();
      chk_out($sformatf("rstwin%0d_run", r), 1, 1, 1, 0, 2'b00, 8'd0, 8'd0);
      next(); next(); next();
      rst = 1'b0;
      next();
      rst = 1'b1;
      chk_out($sformatf("rst_mid_run%0d", r), 0, 0, 0, 0, 2'b00, 8'd0, 8'd0);
    end

    // Randomized traffic against the reference model.
    step_mode = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (i == 0) rst = 1'b0;
      else        rst = ($urandom_range(0, 99) != 0);
      abort   = ($urandom_range(0, 49) == 0);
      start   = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 39) == 0) step_mode = ~step_mode;
      step    = 1'($urandom_range(0, 1));
      halt_in = ($urandom_range(0, 24) == 0);
      retire  = ($urandom_range(0, 9) < 7);
      if (i > 0)
        chk_out($sformatf("random_cycle%0d", i),
                (m_phase == 2 || m_phase == 3), m_en,
                (m_phase == 1 || m_phase == 2), (m_phase == 3),
                2'(m_reason), 8'(m_cyc), 8'(m_ret));
      model_step();
      next();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
